// File: rtl/timer_peripheral.sv
// Memory-mapped timer/SYSTICK/irq block on the data side of MEM; reads return one cycle after the access.
// Always ready: every hit access completes at the clock edge with no backpressure.
module timer_peripheral #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);

  localparam logic [2:0] OFF_TH      = 3'd0;
  localparam logic [2:0] OFF_TL      = 3'd1;
  localparam logic [2:0] OFF_TCON    = 3'd2;
  localparam logic [2:0] OFF_SYSTICK = 3'd5;

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [31:0] systick_q, systick_d;
  logic [31:0] rdata_q, rdata_d;

  logic [2:0] off;
  logic       wr_en;
  logic       rd_en;
  logic       ovf;
  logic       unused_bits;

  assign hit         = (addr[31:5] == BASE_ADDR[31:5]);
  assign off         = addr[4:2];
  assign wr_en       = mem_write & hit;
  assign rd_en       = mem_read & hit;
  assign ovf         = tcon_q[0] & (tl_q == 32'hFFFF_FFFF);
  assign unused_bits = ^{addr[1:0], wdata[31:3]};

  always_comb begin
    th_d      = th_q;
    tl_d      = tl_q;
    tcon_d    = tcon_q;
    systick_d = systick_q + 32'd1;
    rdata_d   = 32'd0;

    if (tcon_q[0]) begin
      tl_d = ovf ? th_q : tl_q + 32'd1;
    end

    if (wr_en) begin
      case (off)
        OFF_TH:   th_d   = wdata;
        OFF_TL:   tl_d   = wdata;
        OFF_TCON: tcon_d = wdata[2:0];
        default:  ;
      endcase
    end

    // Hardware status set is applied after the software write so it wins a same-edge collision.
    if (ovf && tcon_q[1]) begin
      tcon_d[2] = 1'b1;
    end

    if (rd_en) begin
      case (off)
        OFF_TH:      rdata_d = th_q;
        OFF_TL:      rdata_d = tl_q;
        OFF_TCON:    rdata_d = {29'd0, tcon_q};
        OFF_SYSTICK: rdata_d = systick_q;
        default:     rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q      <= 32'd0;
      tl_q      <= 32'd0;
      tcon_q    <= 3'd0;
      systick_q <= 32'd0;
      rdata_q   <= 32'd0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      systick_q <= systick_d;
      rdata_q   <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = tcon_q[1] & tcon_q[2];

endmodule

// File: tb/tb_timer_peripheral.sv
// Scoreboard bench for timer_peripheral: read expectations are queued at issue and checked one cycle later.
module tb_timer_peripheral;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  timer_peripheral #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .hit       (hit),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges seen since reset release; equals SYSTICK between edges.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc_cnt = 0;
    else        cyc_cnt = cyc_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    string       t;
    mem_read  = r;
    mem_write = w;
    addr      = a;
    wdata     = d;
    if (r) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = 32'd0;
    wdata     = 32'd0;
    if (r) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, rdata, e);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus(1'b0, 1'b1, a, d, 32'd0, "");
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    bus(1'b1, 1'b0, a, 32'd0, exp, tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, "");
  endtask

  initial begin
    reset     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = 32'd0;
    wdata     = 32'd0;

    #12;
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    addr = BASE;
    #1 check_eq("hit_base", {31'd0, hit}, 32'd1);
    addr = BASE + 32'h1F;
    #1 check_eq("hit_top", {31'd0, hit}, 32'd1);
    addr = BASE + 32'h20;
    #1 check_eq("hit_above", {31'd0, hit}, 32'd0);
    addr = 32'd0;

    @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rd(BASE + 32'h14, cyc_cnt, "systick_10");
    rd(BASE + 32'h04, 32'd0, "tl_idle");
    rd(BASE + 32'h08, 32'd0, "tcon_idle");
    check_eq("irq_idle", {31'd0, irq}, 32'd0);

    // Overflow and reload.
    wr(BASE + 32'h00, 32'hFFFF_FFFC);
    wr(BASE + 32'h04, 32'hFFFF_FFFC);
    wr(BASE + 32'h08, 32'h3);
    rd(BASE + 32'h04, 32'hFFFF_FFFC, "tl_c0");
    check_eq("irq_c1", {31'd0, irq}, 32'd0);
    rd(BASE + 32'h04, 32'hFFFF_FFFD, "tl_c1");
    rd(BASE + 32'h04, 32'hFFFF_FFFE, "tl_c2");
    check_eq("irq_c3", {31'd0, irq}, 32'd0);
    rd(BASE + 32'h04, 32'hFFFF_FFFF, "tl_c3");
    check_eq("irq_ovf", {31'd0, irq}, 32'd1);
    rd(BASE + 32'h04, 32'hFFFF_FFFC, "tl_reload");
    rd(BASE + 32'h08, 32'h7, "tcon_stat");

    // Software clear, then a clear colliding with the next overflow.
    wr(BASE + 32'h08, 32'h3);
    check_eq("irq_clr", {31'd0, irq}, 32'd0);
    idle(1);
    check_eq("irq_ovf2", {31'd0, irq}, 32'd1);
    idle(3);
    wr(BASE + 32'h08, 32'h3);
    check_eq("irq_hw_wins", {31'd0, irq}, 32'd1);
    rd(BASE + 32'h08, 32'h7, "tcon_hw_wins");

    // TL write overrides increment.
    wr(BASE + 32'h08, 32'h1);
    check_eq("irq_ie_off", {31'd0, irq}, 32'd0);
    wr(BASE + 32'h04, 32'd5);
    wr(BASE + 32'h04, 32'd100);
    rd(BASE + 32'h04, 32'd100, "tl_override");
    rd(BASE + 32'h04, 32'd101, "tl_after");

    // Read-side decode.
    wr(BASE + 32'h08, 32'h5);
    rd(BASE + 32'h08, 32'h5, "tcon_101");
    check_eq("irq_stat_no_ie", {31'd0, irq}, 32'd0);
    idle(1);
    check_eq("rdata_cleared", rdata, 32'd0);
    rd(BASE + 32'h09, 32'h5, "tcon_byteoff");
    for (int k = 0; k < 4; k++) begin
      logic [2:0] offs [4] = '{3'd3, 3'd4, 3'd6, 3'd7};
      wr(BASE + {27'd0, offs[k], 2'b00}, 32'hDEAD_BEEF);
      rd(BASE + {27'd0, offs[k], 2'b00}, 32'd0, $sformatf("hole_%0d", offs[k]));
    end
    rd(BASE + 32'h14, cyc_cnt, "systick_a");
    wr(BASE + 32'h14, 32'd0);
    rd(BASE + 32'h14, cyc_cnt, "systick_wr_ign");

    // Out-of-window accesses and simultaneous read/write.
    mem_write = 1'b1;
    addr      = 32'h0000_0008;
    wdata     = 32'h0;
    #1 check_eq("hit_low", {31'd0, hit}, 32'd0);
    mem_write = 1'b0;
    wr(32'h0000_0008, 32'h0);
    wr(32'h0000_0000, 32'h12);
    rd(BASE + 32'h08, 32'h5, "tcon_nohit");
    rd(BASE + 32'h00, 32'hFFFF_FFFC, "th_nohit");
    rd(32'h0000_0000, 32'd0, "rd_nohit");
    bus(1'b1, 1'b1, BASE, 32'hAA, 32'hFFFF_FFFC, "rw_old");
    rd(BASE, 32'hAA, "rw_new");

    // Asynchronous reset mid-count with irq pending.
    wr(BASE + 32'h08, 32'h7);
    wr(BASE + 32'h04, 32'h1234);
    rd(BASE + 32'h04, 32'h1234, "tl_pre_rst");
    check_eq("irq_pre_rst", {31'd0, irq}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check_eq("rst_async_rdata", rdata, 32'd0);
    check_eq("rst_async_irq", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    idle(3);
    rd(BASE + 32'h04, 32'd0, "tl_post_rst");
    rd(BASE + 32'h08, 32'd0, "tcon_post_rst");
    rd(BASE + 32'h00, 32'd0, "th_post_rst");
    check_eq("sb_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_peripheral.md
Name: timer_peripheral

Overview:
- Memory-mapped timer and interrupt source on the data-memory side of the 5-stage CPU, alongside the data memory.
- Driven by the same MEM-stage access signals as data memory: ALU result as address, store data, read/write strobes.
- Returns read data registered one cycle later, aligned with data-memory read timing into MEM/WB.
- Drives the CPU interrupt input, currently tied to 0.

Parameters:
BASE_ADDR, 32'h4000_0000, word-aligned base of the 32-byte register window.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
mem_read  input  1  load strobe from EX/MEM
mem_write  input  1  store strobe from EX/MEM
addr  input  32  byte address (ALU result)
wdata  input  32  store data
rdata  output  32  registered read data, valid the cycle after the access
hit  output  1  combinational: addr falls inside the window; used by the top level to mux rdata against data memory
irq  output  1  interrupt request to the CPU (TCON[1] & TCON[2])

Behaviour:
- Register map, offset = addr[4:2]; addr[1:0] ignored.
  - 0: TH, reload value, R/W.
  - 1: TL, counter, R/W.
  - 2: TCON, R/W bits [2:0]: bit0 enable, bit1 irq enable, bit2 irq status. Bits [31:3] read 0.
  - 5: SYSTICK, free-running cycle counter, read-only; writes ignored.
  - Offsets 3, 4, 6, 7: read 0, writes ignored.
- hit = (addr[31:5] == BASE_ADDR[31:5]). Accesses with hit=0 are ignored entirely.
- Reset (reset=0, asynchronous): TH, TL, TCON, SYSTICK, rdata all 0; irq=0.
- SYSTICK: increments by 1 every cycle; wraps 32'hFFFF_FFFF -> 0.
- Counter, when TCON[0]=1:
  - TL != 32'hFFFF_FFFF: TL <= TL+1.
  - TL == 32'hFFFF_FFFF: TL <= TH; if TCON[1]=1, TCON[2] <= 1.
- Counter, when TCON[0]=0: TL holds.
- Writes (mem_write & hit) take effect at the clock edge.
  - A TL write overrides the increment or reload in the same cycle.
  - A TCON write loads bits [2:0] from wdata[2:0].
  - If an overflow sets TCON[2] in the same cycle as a TCON write, bit2 = wdata[2] | 1, i.e. hardware set wins. Bits 0 and 1 still come from wdata.
- Reads:
  - When mem_read & hit at edge N, rdata after edge N = register value before edge N (read-before-write, pre-increment).
  - Otherwise rdata <= 0 at each edge.
  - Latency is exactly 1 cycle.
- mem_read and mem_write both 1: write performed, read returns the old value.
- irq is combinational from registered TCON bits; no extra latency beyond the TCON update. It stays high until software clears TCON[2] or TCON[1].
- Reset asserted mid-count clears everything immediately. Counting restarts only after software sets TCON[0].

Test Plan:
- Reset release, no accesses for 10 cycles -> TL=0, TCON=0, irq=0; SYSTICK read at cycle 10 returns 10 on the following cycle (±0, checked against bench counter).
- Write TH=32'hFFFF_FFFC, TL=32'hFFFF_FFFC, TCON=3'b011 -> TL counts FD, FE, FF; next cycle TL=FFFF_FFFC, TCON[2]=1, irq=1 that same cycle.
- With irq=1, write TCON=3'b011 -> irq=0 next cycle; write timed on the overflow edge -> TCON[2] stays 1, irq stays 1.
- TCON[0]=1, TL=5, write TL=100 in the cycle TL would go to 6 -> TL=100, then 101.
- Read addr BASE+0x8 with TCON=3'b101 -> rdata=32'h5 one cycle later, 0 the cycle after with mem_read low. Read BASE+0xC -> 0. Write to BASE+0x14 -> SYSTICK unaffected.
- addr=32'h0000_0008 with mem_write=1 -> hit=0, no register changes. Reset pulsed low mid-count with TL=0x1234 -> TL=0, rdata=0 immediately (asynchronous).
